// File: rtl/screen_ram_arbiter.sv
// screen_ram_arbiter: shares the single screen RAM port between the video renderer and the CPU.
//
// Video has priority. A CPU request that has waited MAX_WAIT cycles takes one RAM cycle away
// from video. In that stolen cycle, video sees its previous byte repeated and vid_miss is raised.
//
// Ports:
//   clk, reset             system clock; synchronous active-high reset
//   vid_en, vid_addr       video read request and address
//   vid_data, vid_miss     video read data (1-cycle latency); stolen-cycle flag
//   cpu_req, cpu_we,       CPU level request held until cpu_ack; write flag, address, write data
//   cpu_addr, cpu_wdata
//   cpu_ack, cpu_rdata     one-cycle completion pulse; read data, valid with cpu_ack
//   ram_en, ram_we,        RAM port (synchronous RAM, read data valid one cycle after address)
//   ram_addr, ram_wdata,
//   ram_rdata
//   stat_steals,           (only with SCREEN_ARB_STATS_EN) saturating counts of stolen cycles
//   stat_cpu_wait          and of cycles where the CPU was eligible but not granted
//
// Optional feature macro: SCREEN_ARB_STATS_EN

module screen_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned WAIT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vid_en,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_miss,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef SCREEN_ARB_STATS_EN
  ,
  output logic [15:0]           stat_steals,
  output logic [15:0]           stat_cpu_wait
`endif
);

  localparam logic [WAIT_WIDTH-1:0] MaxWait = WAIT_WIDTH'(MAX_WAIT);

  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic                  vid_fresh_q;
  logic                  stolen_q;
  logic [DATA_WIDTH-1:0] vid_hold;

  logic cpu_elig;
  logic starved;
  logic gnt_cpu;
  logic gnt_vid;

  // A request is not eligible in its own ack cycle, so it can never be granted twice.
  assign cpu_elig = cpu_req && !cpu_ack;
  assign starved  = (wait_cnt == MaxWait);
  assign gnt_cpu  = cpu_elig && (!vid_en || starved);
  assign gnt_vid  = vid_en && !gnt_cpu;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_cpu) begin
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (gnt_vid) begin
      ram_en    = 1'b1;
      ram_addr  = vid_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      vid_fresh_q <= 1'b0;
      stolen_q    <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_hold    <= '0;
    end else begin
      if (gnt_cpu || !cpu_elig) begin
        wait_cnt <= '0;
      end else if (!starved) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      vid_fresh_q <= gnt_vid;
      stolen_q    <= vid_en && gnt_cpu;
      cpu_ack     <= gnt_cpu;
      // Remember the last fresh byte so a stolen cycle can repeat it.
      if (vid_fresh_q) begin
        vid_hold <= ram_rdata;
      end
    end
  end

  assign vid_data  = vid_fresh_q ? ram_rdata : vid_hold;
  assign vid_miss  = stolen_q;
  assign cpu_rdata = ram_rdata;

`ifdef SCREEN_ARB_STATS_EN
  logic [15:0] steals_q;
  logic [15:0] cpu_wait_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      steals_q   <= '0;
      cpu_wait_q <= '0;
    end else begin
      if (vid_en && gnt_cpu && (steals_q != 16'hFFFF)) begin
        steals_q <= steals_q + 16'd1;
      end
      if (cpu_elig && !gnt_cpu && (cpu_wait_q != 16'hFFFF)) begin
        cpu_wait_q <= cpu_wait_q + 16'd1;
      end
    end
  end

  assign stat_steals   = steals_q;
  assign stat_cpu_wait = cpu_wait_q;
`endif

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// Self-checking bench for screen_ram_arbiter: directed vector table, hand-written multi-cycle
// sequences and randomized traffic checked against a cycle-level reference model.
module tb_screen_ram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_en;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_miss;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef SCREEN_ARB_STATS_EN
  logic [15:0]   stat_steals;
  logic [15:0]   stat_cpu_wait;
`endif

  always #5 clk = ~clk;

  screen_ram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_WAIT  (MW),
    .WAIT_WIDTH(5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vid_en       (vid_en),
    .vid_addr     (vid_addr),
    .vid_data     (vid_data),
    .vid_miss     (vid_miss),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
`ifdef SCREEN_ARB_STATS_EN
    .stat_steals  (stat_steals),
    .stat_cpu_wait(stat_cpu_wait),
`endif
    .ram_rdata    (ram_rdata)
  );

  // Synchronous read-first screen RAM.
  logic [DW-1:0] mem [2048];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int          m_wait;
  bit          m_ack;
  logic [7:0]  m_hold;
  int          m_steals;
  int          m_waits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the RAM mux, clock, then check registered outputs.
  task automatic step(input bit ven, input logic [AW-1:0] va, input bit creq, input bit cwe,
                      input logic [AW-1:0] ca, input logic [DW-1:0] cwd, input bit rst,
                      output bit o_en, output bit o_we);
    bit         elig, gc, gv, steal;
    logic [7:0] exp_vd, exp_rd;
    vid_en = ven; vid_addr = va; cpu_req = creq; cpu_we = cwe; cpu_addr = ca;
    cpu_wdata = cwd; reset = rst;
    #1;
    elig  = creq && !m_ack;
    gc    = elig && (!ven || m_wait == MW);
    gv    = ven && !gc;
    steal = ven && gc;
    o_en  = ram_en;
    o_we  = ram_we;
    check("ram_en", {31'b0, ram_en}, {31'b0, gc || gv});
    check("ram_we", {31'b0, ram_we}, {31'b0, gc && cwe});
    check("ram_addr", {21'b0, ram_addr}, {21'b0, gc ? ca : (gv ? va : 11'd0)});
    if (gc) check("ram_wdata", {24'b0, ram_wdata}, {24'b0, cwd});
    exp_vd = gv ? mem[va] : m_hold;
    exp_rd = mem[ca];
    @(posedge clk);
    #1;
    if (rst) begin
      m_wait = 0; m_ack = 1'b0; m_hold = 8'h00; m_steals = 0; m_waits = 0;
      check("rst_ack", {31'b0, cpu_ack}, 32'd0);
      check("rst_miss", {31'b0, vid_miss}, 32'd0);
      check("rst_vid_data", {24'b0, vid_data}, 32'd0);
    end else begin
      if (elig && !gc && m_waits < 65535) m_waits++;
      if (steal && m_steals < 65535) m_steals++;
      m_wait = (gc || !elig) ? 0 : ((m_wait + 1 > MW) ? MW : m_wait + 1);
      m_ack  = gc;
      m_hold = exp_vd;
      check("cpu_ack", {31'b0, cpu_ack}, {31'b0, gc});
      check("vid_miss", {31'b0, vid_miss}, {31'b0, steal});
      check("vid_data", {24'b0, vid_data}, {24'b0, exp_vd});
      if (gc && !cwe) check("cpu_rdata", {24'b0, cpu_rdata}, {24'b0, exp_rd});
    end
  endtask

  task automatic do_reset();
    bit e, w;
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, e, w);
  endtask

  typedef struct {
    bit            ven;
    logic [AW-1:0] va;
    bit            creq;
    bit            cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cwd;
    bit            en;
    bit            we;
    bit            ack;
    bit            chk_rd;
    logic [DW-1:0] rd;
    bit            chk_vd;
    logic [DW-1:0] vd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit            e, w;
    bit            creq, cwe, prev_ack;
    logic [AW-1:0] ca;
    logic [DW-1:0] cwd;
    int            nsteal, last_steal;
    bit            prev_miss;

    ram_rdata = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
    m_wait = 0; m_ack = 1'b0; m_hold = 8'h00; m_steals = 0; m_waits = 0;
    vid_en = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    reset = 1;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // Video idle: CPU write then read back.
    vecs[0] = '{0, 11'h000, 1, 1, 11'h210, 8'h5A, 1, 1, 1, 0, 8'h00, 0, 8'h00};
    vecs[1] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[2] = '{0, 11'h000, 1, 0, 11'h210, 8'h00, 1, 0, 1, 1, 8'h5A, 0, 8'h00};
    vecs[3] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h00};
    vecs[4] = '{1, 11'h210, 0, 0, 11'h000, 8'h00, 1, 0, 0, 0, 8'h00, 1, 8'h5A};
    vecs[5] = '{0, 11'h000, 0, 0, 11'h000, 8'h00, 0, 0, 0, 0, 8'h00, 1, 8'h5A};
    foreach (vecs[i]) begin
      step(vecs[i].ven, vecs[i].va, vecs[i].creq, vecs[i].cwe, vecs[i].ca, vecs[i].cwd, 1'b0,
           e, w);
      check("vec_ram_en", {31'b0, e}, {31'b0, vecs[i].en});
      check("vec_ram_we", {31'b0, w}, {31'b0, vecs[i].we});
      check("vec_ack", {31'b0, cpu_ack}, {31'b0, vecs[i].ack});
      if (vecs[i].chk_rd) check("vec_rdata", {24'b0, cpu_rdata}, {24'b0, vecs[i].rd});
      if (vecs[i].chk_vd) check("vec_vid_data", {24'b0, vid_data}, {24'b0, vecs[i].vd});
    end

    // Continuous video with a waiting CPU read: steal on the 17th cycle, ack on the 18th.
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      step(1'b1, 11'(11'h200 + k), 1'b1, 1'b0, 11'h210, 8'h00, 1'b0, e, w);
      if (k < 16) check("s2_no_ack", {31'b0, cpu_ack}, 32'd0);
    end
    check("s2_ack", {31'b0, cpu_ack}, 32'd1);
    check("s2_miss", {31'b0, vid_miss}, 32'd1);
    check("s2_repeat", {24'b0, vid_data}, {24'b0, mem[11'h20F]});
    check("s2_rdata", {24'b0, cpu_rdata}, 32'h5A);
    step(1'b1, 11'h211, 1'b0, 1'b0, 11'h000, 8'h00, 1'b0, e, w);
`ifdef SCREEN_ARB_STATS_EN
    check("s2_stat_steals", {16'b0, stat_steals}, 32'd1);
    check("s2_stat_cpu_wait", {16'b0, stat_cpu_wait}, 32'd16);
`endif

    // Continuous video, CPU request held for 100 cycles.
    do_reset();
    nsteal = 0; last_steal = -100; prev_miss = 0; ca = 11'h300;
    for (int k = 0; k < 100; k++) begin
      prev_ack = cpu_ack;
      step(1'b1, 11'(11'h200 + k), 1'b1, 1'b0, ca, 8'h00, 1'b0, e, w);
      if (prev_ack && cpu_ack) check("s3_grant_in_ack", 32'd1, 32'd0);
      if (vid_miss) begin
        if (prev_miss) check("s3_consecutive_steal", 32'd1, 32'd0);
        if (k - last_steal < MW + 1) check("s3_steal_gap", k - last_steal, MW + 1);
        nsteal++;
        last_steal = k;
        ca = ca + 11'd1;
      end
      prev_miss = vid_miss;
    end
    check("s3_steal_count", nsteal, 5);

    // Video toggling with CPU request held: granted in the first idle video cycle.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      step(k[0] == 1'b0, 11'(11'h100 + k), 1'b1, 1'b1, 11'h400, 8'(k), 1'b0, e, w);
      if (k == 0) check("s4_first_wait", {31'b0, cpu_ack}, 32'd0);
      if (k == 1) check("s4_first_idle_ack", {31'b0, cpu_ack}, 32'd1);
      check("s4_no_miss", {31'b0, vid_miss}, 32'd0);
    end

    // Reset in the cycle after a CPU grant; request still asserted afterwards.
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 11'h300, 8'h77, 1'b0, e, w);
    check("s5_ack_before_reset", {31'b0, cpu_ack}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b1, 11'h300, 8'h77, 1'b1, e, w);
    step(1'b0, '0, 1'b1, 1'b1, 11'h300, 8'h77, 1'b0, e, w);
    check("s5_reack", {31'b0, cpu_ack}, 32'd1);
    check("s5_mem", {24'b0, mem[11'h300]}, 32'h77);
    // Reset with a partly elapsed wait count must restart the full wait.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 11'(k), 1'b1, 1'b0, 11'h10, 8'h0, 1'b0, e, w);
    do_reset();
    for (int k = 0; k < 18; k++) step(1'b1, 11'(k), 1'b1, 1'b0, 11'h10, 8'h0, 1'b0, e, w);

    // Randomized traffic against the model.
    do_reset();
    creq = 0; cwe = 0; ca = '0; cwd = '0;
    for (int k = 0; k < 3000; k++) begin
      if (creq && cpu_ack) begin
        creq = ($urandom_range(0, 1) == 0);
      end else if (creq && $urandom_range(0, 63) == 0) begin
        creq = 0;
      end else if (!creq) begin
        creq = ($urandom_range(0, 2) == 0);
      end
      if (creq && (cpu_ack || !cpu_req)) begin
        cwe = $urandom_range(0, 1) == 1;
        ca  = 11'(11'h200 + $urandom_range(0, 15));
        cwd = 8'($urandom);
      end
      step($urandom_range(0, 3) != 0, 11'(11'h200 + $urandom_range(0, 15)), creq, cwe, ca, cwd,
           $urandom_range(0, 499) == 0, e, w);
    end
`ifdef SCREEN_ARB_STATS_EN
    check("rand_stat_steals", {16'b0, stat_steals}, m_steals);
    check("rand_stat_cpu_wait", {16'b0, stat_cpu_wait}, m_waits);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
